irq_encoder_15x4: RTL and testbench

- Interrupt request encoder: collapses the 15 SPARC interrupt request lines into the 4-bit IRL presented to the integer unit trap logic.
- Functional inverse of the 2x4/NxM decoders in the decode stage.
- Synchronises and edge-detects requests, holds them pending, and selects the highest eligible level against PIL/ET.
- Presents the selected level through a valid/ack handshake; ack clears that level's pending bit.

---
 rtl/irq_encoder_15x4.sv | 124 ++++++++++++
 tb/tb_irq_encoder_15x4.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_encoder_15x4.sv
// Interrupt request encoder: synchronises and edge-detects 15 request lines,
// holds them pending and presents the highest eligible level over valid/ack.
module irq_encoder_15x4 #(
    parameter int N_LINES     = 15,
    parameter int LEVEL_W     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] irq_in,
    input  logic [LEVEL_W-1:0] pil,
    input  logic               et,
    input  logic               irq_ack,
    output logic [LEVEL_W-1:0] irl_out,
    output logic               irq_valid,
    output logic [N_LINES-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_CLEAR
    } state_e;

    logic [SYNC_STAGES-1:0][N_LINES-1:0] sync_q, sync_d;
    logic [N_LINES-1:0]                  edge_q;
    logic [N_LINES-1:0]                  rise;
    logic [N_LINES-1:0]                  pending_q, pending_d;
    logic [N_LINES-1:0]                  eligible;
    logic [N_LINES-1:0]                  sel_mask;
    logic [N_LINES-1:0]                  clr_mask;
    logic [LEVEL_W-1:0]                  winner;
    logic [LEVEL_W-1:0]                  irl_q, irl_d;
    state_e                              state_q, state_d;

    // Stage 0 captures the asynchronous pins; the last stage feeds edge detection.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
    assign rise   = sync_q[SYNC_STAGES-1] & ~edge_q;

    // The top line is non-maskable by PIL but still gated by ET.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_LINES; i++) begin
            eligible[i] = pending_q[i] & et &
                          ((LEVEL_W'(i + 1) > pil) || (i == N_LINES - 1));
        end
    end

    // Ascending scan: the last eligible line seen is the highest level.
    always_comb begin
        winner = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (eligible[i]) begin
                winner = LEVEL_W'(i + 1);
            end
        end
    end

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < N_LINES; i++) begin
            sel_mask[i] = (irl_q == LEVEL_W'(i + 1));
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        irl_d    = irl_q;
        clr_mask = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d = ST_ASSERT;
                    irl_d   = winner;
                end
            end
            ST_ASSERT: begin
                if (irq_ack) begin
                    clr_mask = sel_mask;
                    state_d  = ST_CLEAR;
                    irl_d    = '0;
                end else if (!(|(eligible & sel_mask))) begin
                    state_d = ST_IDLE;
                    irl_d   = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
                irl_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                irl_d   = '0;
            end
        endcase
    end

    // A fresh detect on the acknowledged line wins over its clear.
    assign pending_d = (pending_q & ~clr_mask) | rise;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    // NOTE: sync chain and edge history are reset too; otherwise a line high at release could look like a fresh or missed edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            edge_q    <= '0;
            pending_q <= '0;
            irl_q     <= '0;
            state_q   <= ST_IDLE;
        end else begin
            sync_q    <= sync_d;
            edge_q    <= sync_q[SYNC_STAGES-1];
            pending_q <= pending_d;
            irl_q     <= irl_d;
            state_q   <= state_d;
        end
    end

    assign irl_out   = irl_q;
    assign irq_valid = (state_q == ST_ASSERT);
    assign pending   = pending_q;

endmodule

// File: tb/tb_irq_encoder_15x4.sv
// Self-checking bench for irq_encoder_15x4: directed scenarios plus random
// stimulus, compared every cycle against a history-based behavioural model.
module tb_irq_encoder_15x4;

    localparam int N     = 15;
    localparam int LW    = 4;
    localparam int SYNC  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_in;
    logic [LW-1:0] pil;
    logic          et;
    logic          irq_ack;
    logic [LW-1:0] irl_out;
    logic          irq_valid;
    logic [N-1:0]  pending;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model: sampled input history, pending set, presented level (0 = none),
    // and a one-cycle cooldown after an acknowledge.
    logic [N-1:0] hist [SYNC+2];
    logic [N-1:0] m_pend;
    int           m_pres;
    bit           m_cool;

    irq_encoder_15x4 #(.N_LINES(N), .LEVEL_W(LW), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .pil       (pil),
        .et        (et),
        .irq_ack   (irq_ack),
        .irl_out   (irl_out),
        .irq_valid (irq_valid),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit level_ok(input logic [N-1:0] pend, input int lvl);
        return pend[lvl-1] && et && ((lvl > int'(pil)) || (lvl == 15));
    endfunction

    function automatic int best_level(input logic [N-1:0] pend);
        for (int l = 15; l >= 1; l--) begin
            if (level_ok(pend, l)) return l;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        m_pend = '0;
        m_pres = 0;
        m_cool = 1'b0;
        for (int k = 0; k < SYNC + 2; k++) hist[k] = '0;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    function automatic void model_step();
        logic [N-1:0] set_m;
        logic [N-1:0] clr_m;
        for (int k = SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = irq_in;
        set_m = hist[SYNC] & ~hist[SYNC+1];
        clr_m = '0;
        if (m_pres != 0) begin
            if (irq_ack) begin
                clr_m[m_pres-1] = 1'b1;
                m_pres = 0;
                m_cool = 1'b1;
            end else if (!level_ok(m_pend, m_pres)) begin
                m_pres = 0;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else begin
            m_pres = best_level(m_pend);
        end
        m_pend = (m_pend & ~clr_m) | set_m;
    endfunction

    always @(posedge clk) begin
        #1;
        if (check_en) begin
            check("irq_valid", 32'(irq_valid), 32'(m_pres != 0));
            check("irl_out", 32'(irl_out), 32'(m_pres));
            check("pending", 32'(pending), 32'(m_pend));
        end
    end

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 20 && !irq_valid; k++) cycle();
        check(name, 32'(irq_valid), 32'd1);
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        irq_in  = '0;
        pil     = '0;
        et      = 1'b1;
        irq_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(irq_valid), 32'd0);
        check("reset_irl", 32'(irl_out), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        rst_n    = 1'b1;
        check_en = 1'b1;
        cycle(2);

        // Single request on level 5
        irq_in[4] = 1'b1;
        cycle(3);
        check("single_pend_e3", 32'(pending), 32'h0010);
        check("single_valid_e3", 32'(irq_valid), 32'd0);
        cycle();
        check("single_valid_e4", 32'(irq_valid), 32'd1);
        check("single_irl_e4", 32'(irl_out), 32'd5);
        ack_pulse();
        check("single_clear_valid", 32'(irq_valid), 32'd0);
        check("single_clear_pend", 32'(pending), 32'h0000);
        irq_in = '0;
        cycle(4);

        // Priority and no preemption
        irq_in[2] = 1'b1;
        irq_in[6] = 1'b1;
        cycle(4);
        check("prio_first", 32'(irl_out), 32'd7);
        irq_in[11] = 1'b1;
        cycle(5);
        check("prio_no_preempt", 32'(irl_out), 32'd7);
        ack_pulse();
        wait_valid("prio_wait12");
        check("prio_second", 32'(irl_out), 32'd12);
        ack_pulse();
        wait_valid("prio_wait3");
        check("prio_third", 32'(irl_out), 32'd3);
        ack_pulse();
        irq_in = '0;
        cycle(4);

        // PIL masking and ET gating
        pil = 4'd10;
        irq_in[7]  = 1'b1;
        irq_in[14] = 1'b1;
        wait_valid("pil_wait15");
        check("pil_nmi", 32'(irl_out), 32'd15);
        ack_pulse();
        cycle(6);
        check("pil_masked_valid", 32'(irq_valid), 32'd0);
        check("pil_masked_pend", 32'(pending), 32'h0080);
        pil = 4'd7;
        wait_valid("pil_wait8");
        check("pil_lowered", 32'(irl_out), 32'd8);
        ack_pulse();
        irq_in = '0;
        et = 1'b0;
        irq_in[9] = 1'b1;
        cycle(8);
        check("et_off_valid", 32'(irq_valid), 32'd0);
        check("et_off_pend", 32'(pending), 32'h0200);
        et  = 1'b1;
        pil = 4'd0;
        wait_valid("et_wait10");
        check("et_on", 32'(irl_out), 32'd10);
        ack_pulse();
        irq_in = '0;
        cycle(4);

        // Retraction by raising PIL
        irq_in[5] = 1'b1;
        wait_valid("retract_wait6");
        check("retract_first", 32'(irl_out), 32'd6);
        pil = 4'd6;
        cycle();
        check("retract_valid", 32'(irq_valid), 32'd0);
        check("retract_pend", 32'(pending), 32'h0020);
        pil = 4'd0;
        wait_valid("retract_wait6b");
        check("retract_again", 32'(irl_out), 32'd6);
        ack_pulse();
        irq_in = '0;
        cycle(4);

        // New edge on level 4 landing in the same cycle as its ack
        irq_in[3] = 1'b1;
        wait_valid("simul_wait4");
        check("simul_first", 32'(irl_out), 32'd4);
        irq_in[3] = 1'b0;
        cycle(3);
        irq_in[3] = 1'b1;
        cycle(2);
        ack_pulse();
        check("simul_clear_valid", 32'(irq_valid), 32'd0);
        check("simul_pend_kept", 32'(pending), 32'h0008);
        wait_valid("simul_wait4b");
        check("simul_again", 32'(irl_out), 32'd4);
        ack_pulse();
        irq_in = '0;
        cycle(4);

        // Ack while idle changes nothing
        et = 1'b0;
        irq_in[1] = 1'b1;
        cycle(4);
        irq_ack = 1'b1;
        cycle(3);
        irq_ack = 1'b0;
        check("idle_ack_pend", 32'(pending), 32'h0002);
        check("idle_ack_valid", 32'(irq_valid), 32'd0);
        et = 1'b1;
        wait_valid("idle_wait2");
        check("idle_present", 32'(irl_out), 32'd2);
        ack_pulse();
        irq_in = '0;
        cycle(4);

        // Asynchronous reset while level 9 is presented
        irq_in[8] = 1'b1;
        wait_valid("rst_wait9");
        check("rst_pre", 32'(irl_out), 32'd9);
        check_en = 1'b0;
        rst_n    = 1'b0;
        irq_in   = '0;
        #1;
        check("rst_async_valid", 32'(irq_valid), 32'd0);
        check("rst_async_irl", 32'(irl_out), 32'd0);
        check("rst_async_pend", 32'(pending), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;
        cycle(8);
        check("rst_after_valid", 32'(irq_valid), 32'd0);

        // Random phase
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 11) == 0) irq_in[b] = ~irq_in[b];
            end
            if ($urandom_range(0, 39) == 0) pil = LW'($urandom_range(0, 15));
            et = ($urandom_range(0, 19) != 0);
            if (m_pres != 0) irq_ack = ($urandom_range(0, 3) == 0);
            else             irq_ack = ($urandom_range(0, 9) == 0);
            cycle();
        end
        irq_ack = 1'b0;
        cycle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
